fp_addsub_sched: RTL and testbench
==================================

// Module: fp_addsub_sched
// PURPOSE
//  Round-robin scheduler sharing one pipelined FP add/sub unit (fixed latency, ce-gated) among
//  NREQ requesters. Grants one operation per cycle, registers operands into the unit, and tags
//  each issued op with its requester ID through a valid/tag shift register matched to the unit
//  latency. Each result is returned as a one-cycle pulse to the issuing requester.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  FPWID  32  operand/result width
//  LAT    5   cycles from fu_a/fu_b presented (fu_ce=1) to matching fu_o valid (>=1)
// PORTS
//  clk      in   1           clock, all state on rising edge
//  rst      in   1           synchronous, active-high reset
//  req      in   NREQ        per-requester operation request, held until granted
//  op       in   NREQ        per-requester op: 0=add, 1=subtract
//  rm       in   3*NREQ      per-requester rounding mode, slice [3i+2:3i]
//  a_i      in   FPWID*NREQ  per-requester operand A, slice i
//  b_i      in   FPWID*NREQ  per-requester operand B, slice i
//  stall    in   1           global freeze of scheduler and unit
//  gnt      out  NREQ        one-hot grant (combinational); operands taken when req[i]&gnt[i]
//  fu_ce    out  1           unit clock enable = ~stall
//  fu_op    out  1           registered op to unit
//  fu_rm    out  3           registered rounding mode to unit
//  fu_a     out  FPWID       registered operand A to unit
//  fu_b     out  FPWID       registered operand B to unit
//  fu_o     in   FPWID       unit result
//  res_vld  out  NREQ        one-hot result strobe, one cycle per completed op
//  res_o    out  FPWID       result data (= fu_o), valid only with res_vld
//  busy     out  1           any op in issue register or shift register
// BEHAVIOUR
//  Reset: gnt=0, res_vld=0, fu_a/fu_b=0, fu_op=0, fu_rm=0, all valid/tag bits 0, rr pointer=0.
//  - gnt forced 0 while rst=1 or stall=1.
//  Arbitration: rr pointer p = highest-priority index; winner = first i with req[i] scanning
//   p, p+1, ... wrapping mod NREQ. On a grant to w, p <= (w+1) mod NREQ; no grant -> p holds.
//  Issue: cycle G with req[w]&gnt[w]: at end of G fu_a<=a_i[w], fu_b<=b_i[w], fu_op<=op[w],
//   fu_rm<=rm[w], issue valid<=1, tag<=w. No grant -> issue valid<=0, operand regs hold.
//  Tracking: issue {valid,tag} feeds an LAT-deep shift register, advancing only when stall=0.
//  Completion: tail entry valid & stall=0 -> res_vld[tag]=1, res_o=fu_o. Without stalls the
//   result for a grant in cycle G appears in cycle G+1+LAT. Results return in issue order.
//  Throughput: one grant per unstalled cycle; no per-requester limit; no result backpressure
//   (requesters must accept the res_vld pulse).
//  Stall: fu_ce=0, issue and shift registers hold, p holds, gnt=0, res_vld=0; a pending tail
//   result reasserts on the first unstalled cycle with unchanged data (unit frozen by fu_ce).
//  Simultaneous grant and completion for the same requester in one cycle: both occur normally.
//  Reset mid-operation: all in-flight ops discarded; no res_vld after rst deasserts until new
//   grants; a requester still holding req is re-arbitrated from p=0.
//  busy = issue valid | any shift-register valid bit.
// TESTING
//  1 req[0], a=3F800000 b=40000000 op=0 -> gnt[0] cycle G; res_vld=0001, res_o=40400000 at G+6.
//  2 req[2], a=40400000 b=3F800000 op=1 -> res_vld=0100, res_o=40000000 exactly LAT+1 later.
//  3 req=1111 held 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; res_vld same order, tags correct.
//  4 req=1010 held -> grants alternate 1,3,1,3; p wraps 3->0 and skips idle 0,2.
//  5 stall=1 for 3 cycles with 3 ops in flight -> no gnt/res_vld during stall; results arrive
//    3 cycles late with correct values and tags; busy stays 1 throughout.
//  6 rst pulsed with 4 ops in flight -> res_vld stays 0, busy=0 next cycle, next grant from p=0.

Source files
------------

// File: rtl/fp_addsub_sched.sv
// Round-robin issue scheduler for one shared pipelined FP add/sub unit.
// Each issued op is tagged with its requester and returned as a result pulse.
module fp_addsub_sched #(
   parameter int NREQ  = 4,
   parameter int FPWID = 32,
   parameter int LAT   = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        op,
   input  logic [3*NREQ-1:0]      rm,
   input  logic [FPWID*NREQ-1:0]  a_i,
   input  logic [FPWID*NREQ-1:0]  b_i,
   input  logic                   stall,
   output logic [NREQ-1:0]        gnt,
   output logic                   fu_ce,
   output logic                   fu_op,
   output logic [2:0]             fu_rm,
   output logic [FPWID-1:0]       fu_a,
   output logic [FPWID-1:0]       fu_b,
   input  logic [FPWID-1:0]       fu_o,
   output logic [NREQ-1:0]        res_vld,
   output logic [FPWID-1:0]       res_o,
   output logic                   busy
);

   localparam int PW = $clog2(NREQ);

   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic          found;
   logic          take;

   logic          iss_v;
   logic [PW-1:0] iss_tag;
   logic [LAT-1:0] sr_v;
   logic [PW-1:0] sr_tag [LAT];

   // scan from ptr upward, wrapping, first active request wins
   always_comb begin : arb
      int idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
   end

   assign take  = found & ~rst & ~stall;
   assign fu_ce = ~stall;

   always_comb begin
      gnt = '0;
      if (take) gnt[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr     <= '0;
         iss_v   <= 1'b0;
         iss_tag <= '0;
         fu_op   <= 1'b0;
         fu_rm   <= '0;
         fu_a    <= '0;
         fu_b    <= '0;
         sr_v    <= '0;
         for (int k = 0; k < LAT; k++) sr_tag[k] <= '0;
      end else if (!stall) begin
         iss_v <= take;
         if (take) begin
            ptr     <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
            iss_tag <= win;
            fu_op   <= op[win];
            fu_rm   <= rm[3*int'(win) +: 3];
            fu_a    <= a_i[FPWID*int'(win) +: FPWID];
            fu_b    <= b_i[FPWID*int'(win) +: FPWID];
         end
         // tag pipe runs in lockstep with the unit's ce
         sr_v[0]   <= iss_v;
         sr_tag[0] <= iss_tag;
         for (int k = 1; k < LAT; k++) begin
            sr_v[k]   <= sr_v[k-1];
            sr_tag[k] <= sr_tag[k-1];
         end
      end
   end

   always_comb begin
      res_vld = '0;
      if (sr_v[LAT-1] && !stall && !rst) res_vld[sr_tag[LAT-1]] = 1'b1;
   end

   assign res_o = fu_o;
   assign busy  = iss_v | (|sr_v);

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: bench-side FP unit, queue-based reference
// model checked every cycle, directed literal cases, then random traffic.
module tb_fp_addsub_sched;

   localparam int NREQ = 4;
   localparam int FW   = 32;
   localparam int LAT  = 5;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   op;
   logic [3*NREQ-1:0] rm;
   logic [FW*NREQ-1:0] a_i;
   logic [FW*NREQ-1:0] b_i;
   logic              stall;
   logic [NREQ-1:0]   gnt;
   logic              fu_ce;
   logic              fu_op;
   logic [2:0]        fu_rm;
   logic [FW-1:0]     fu_a;
   logic [FW-1:0]     fu_b;
   logic [FW-1:0]     fu_o;
   logic [NREQ-1:0]   res_vld;
   logic [FW-1:0]     res_o;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 0;

   fp_addsub_sched #(.NREQ(NREQ), .FPWID(FW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .rm(rm),
      .a_i(a_i), .b_i(b_i), .stall(stall), .gnt(gnt),
      .fu_ce(fu_ce), .fu_op(fu_op), .fu_rm(fu_rm),
      .fu_a(fu_a), .fu_b(fu_b), .fu_o(fu_o),
      .res_vld(res_vld), .res_o(res_o), .busy(busy)
   );

   always #5 clk = ~clk;

   // float32 <-> real for normal values and zero
   function automatic real f2r(logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fpres(logic [31:0] a, logic [31:0] b,
                                         logic s);
      return r2f(s ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
   endfunction

   // bench-side FP unit: fixed latency, frozen when fu_ce=0
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      if (fu_ce) begin
         pipe[0] <= fpres(fu_a, fu_b, fu_op);
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
   end
   assign fu_o = pipe[LAT-1];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // reference model: arbitration pointer, in-flight queue, issue regs
   typedef struct {
      int          w;
      logic [31:0] r;
      int          rem;
   } ent_t;

   ent_t        q[$];
   int          p = 0;
   logic [31:0] ea = '0, eb = '0;
   logic        eop = 1'b0;
   logic [2:0]  erm = '0;

   always @(negedge clk) begin
      if (chk_on) begin
         logic [NREQ-1:0] eg, ev;
         logic [31:0] ed;
         int w, i;
         eg = '0; ev = '0; ed = '0; w = -1; i = 0;
         if (!rst && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
               i = (p + k) % NREQ;
               if (w < 0 && req[i]) w = i;
            end
            if (w >= 0) eg[w] = 1'b1;
            if (q.size() > 0 && q[0].rem == 0) begin
               ev[q[0].w] = 1'b1;
               ed = q[0].r;
            end
         end
         chk("gnt", gnt, eg);
         chk("res_vld", res_vld, ev);
         if (ev != 0) chk("res_o", res_o, ed);
         chk("busy", busy, q.size() != 0);
         chk("fu_ce", fu_ce, !stall);
         chk("fu_a", fu_a, ea);
         chk("fu_b", fu_b, eb);
         chk("fu_op", fu_op, eop);
         chk("fu_rm", fu_rm, erm);
         if (rst) begin
            q.delete();
            p = 0; ea = '0; eb = '0; eop = 1'b0; erm = '0;
         end else if (!stall) begin
            if (ev != 0) void'(q.pop_front());
            foreach (q[j]) q[j].rem--;
            if (w >= 0) begin
               ea  = a_i[FW*w +: FW];
               eb  = b_i[FW*w +: FW];
               eop = op[w];
               erm = rm[3*w +: 3];
               q.push_back('{w: w, r: fpres(ea, eb, eop), rem: LAT});
               p = (w + 1) % NREQ;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_op(int i);
      a_i[FW*i +: FW] = r2f(real'($urandom_range(1, 4000)));
      b_i[FW*i +: FW] = r2f(real'($urandom_range(1, 4000)));
      op[i] = 1'($urandom);
      rm[3*i +: 3] = 3'($urandom);
   endtask

   task automatic wait_res(output int k, output logic [NREQ-1:0] v,
                           output logic [31:0] d);
      k = 0; v = '0; d = '0;
      for (int n = 1; n <= 20 && v == 0; n++) begin
         @(negedge clk);
         if (res_vld != 0) begin
            k = n; v = res_vld; d = res_o;
         end
      end
   endtask

   function automatic int oh2i(logic [NREQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NREQ; i++)
         if (v == NREQ'(1 << i)) r = i;
      return r;
   endfunction

   initial begin
      int k;
      logic [NREQ-1:0] v, g;
      logic [31:0] d;
      int s3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int s4 [4] = '{1, 3, 1, 3};

      rst = 1'b1; stall = 1'b0; req = '0; op = '0; rm = '0;
      a_i = '0; b_i = '0;
      tick();
      chk_on = 1;
      tick();
      rst = 1'b0;

      // 1.0 + 2.0 from requester 0
      a_i[0 +: FW] = 32'h3F800000;
      b_i[0 +: FW] = 32'h40000000;
      op[0] = 1'b0;
      req = 4'b0001;
      @(negedge clk);
      chk("t1_gnt", gnt, 4'b0001);
      tick();
      req = '0;
      wait_res(k, v, d);
      chk("t1_lat", k, LAT + 1);
      chk("t1_vld", v, 4'b0001);
      chk("t1_res", d, 32'h40400000);
      tick();

      // 3.0 - 1.0 from requester 2
      a_i[2*FW +: FW] = 32'h40400000;
      b_i[2*FW +: FW] = 32'h3F800000;
      op[2] = 1'b1;
      req = 4'b0100;
      tick();
      req = '0;
      wait_res(k, v, d);
      chk("t2_lat", k, LAT + 1);
      chk("t2_vld", v, 4'b0100);
      chk("t2_res", d, 32'h40000000);
      tick();

      rst = 1'b1;
      tick();
      rst = 1'b0;

      // all requesting: strict rotation
      for (int i = 0; i < NREQ; i++) new_op(i);
      req = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("t3_seq", oh2i(gnt), s3[n]);
         tick();
      end
      req = 4'b1010;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("t4_seq", oh2i(gnt), s4[n]);
         tick();
      end
      req = '0;
      repeat (LAT + 3) tick();

      // three ops in flight, then a 3-cycle stall
      for (int i = 0; i < NREQ; i++) new_op(i);
      req = 4'b0111;
      repeat (3) tick();
      req = 4'b1000;
      stall = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("t5_busy", busy, 1'b1);
         chk("t5_gnt", gnt, 4'b0000);
         chk("t5_vld", res_vld, 4'b0000);
         tick();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("t5_resume_gnt", gnt, 4'b1000);
      tick();
      req = '0;
      repeat (LAT + 6) tick();

      // reset with four ops in flight, requests still held
      req = 4'b1111;
      repeat (4) tick();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_gnt", gnt, 4'b0000);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_busy", busy, 1'b0);
      chk("t6_gnt", gnt, 4'b0001);
      tick();
      req = '0;
      repeat (LAT + 4) tick();

      // random traffic with stalls and occasional resets
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         g = gnt;
         tick();
         rst = ($urandom_range(0, 99) == 0);
         stall = ($urandom_range(0, 9) == 0);
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && g[i]) req[i] = 1'b0;
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               new_op(i);
               req[i] = 1'b1;
            end
         end
      end
      rst = 1'b0; stall = 1'b0; req = '0;
      repeat (LAT + 6) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_bad);
      $finish;
   end

endmodule
